// File: rtl/fast2slow_counter_xfer.sv
// rtl/fast2slow_counter_xfer.sv - up/down counter with Gray copy and toggle-handshake snapshot to a slow domain
module fast2slow_counter_xfer #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             ack_tgl,
  output logic [WIDTH-1:0] count_1,
  output logic [WIDTH-1:0] count_gray,
  output logic [WIDTH-1:0] hold_data,
  output logic             req_tgl,
  output logic             busy,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       count_q, count_d;
  logic [WIDTH-1:0]       gray_q;
  logic [WIDTH-1:0]       hold_q;
  logic                   ovf_q, ovf_d;
  logic                   req_q;
  logic                   busy_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      if (up_down) begin
        if (count_q == MAX_VAL) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // Gray is derived from the next-state value so it never lags count_1.
  always_ff @(posedge clk1) begin
    if (reset) begin
      count_q <= '0;
      gray_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= count_d ^ (count_d >> 1);
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_tgl};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Snapshot is the pre-update count, so a wrap on the capture edge yields the old value.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q  <= count_q;
          req_q   <= ~req_q;
          busy_q  <= 1'b1;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_s == req_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign count_1    = count_q;
  assign count_gray = gray_q;
  assign hold_data  = hold_q;
  assign req_tgl    = req_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule
